btb_predictor: RTL and testbench

Fetch-side branch target buffer that serves the write port driven by the branch functional unit. It stores 256 direct-mapped target entries indexed by PC[9:2], accepts taken-branch/jump updates from the branch FU, and answers fetch lookups one cycle later with a predicted-taken flag and target address. Its `bp`/`bp_addr` outputs travel with the instruction through decode, so the branch FU can confirm or correct the prediction.

---
 rtl/btb_predictor.sv | 106 ++++++++++
 tb/tb_btb_predictor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer: BFU write port, 1-cycle fetch lookup with write-first bypass.
// Optional tag storage and tag-match on hit is compiled in by defining BTB_TAG_CHECK_EN.
module btb_predictor #(
  parameter int ENTRIES  = 256,
  parameter int IDX_BITS = 8,
  parameter int TAG_BITS = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_req,
  input  logic [31:0]         lookup_pc,
  input  logic                lookup_stall,
  input  logic                flush,
  input  logic                btb_web,
  input  logic [IDX_BITS-1:0] btb_addr,
  input  logic [31:0]         btb_din,
  input  logic [TAG_BITS-1:0] btb_wtag,
  output logic                resp_valid,
  output logic                bp,
  output logic [31:0]         bp_addr
);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [ENTRIES-1:0] valid;
  logic [31:0]        target [ENTRIES];

  logic [IDX_BITS-1:0] idx;
  logic                byp;
  logic                hit;
  logic [31:0]         tgt;

  state_t      state_q, state_d;
  logic        bp_d;
  logic [31:0] addr_d;

  assign idx = lookup_pc[IDX_BITS+1:2];
  assign byp = !btb_web && (btb_addr == idx);
  assign tgt = byp ? btb_din : target[idx];

  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (!btb_web) valid[btb_addr] <= 1'b1;
  end

  // Targets need no reset: the valid bit gates every use.
  always_ff @(posedge clk) begin
    if (!rst && !btb_web) target[btb_addr] <= btb_din;
  end

`ifdef BTB_TAG_CHECK_EN
  logic [TAG_BITS-1:0] tag [ENTRIES];
  logic [TAG_BITS-1:0] tag_rd;
  logic                unused_bits;

  always_ff @(posedge clk) begin
    if (!rst && !btb_web) tag[btb_addr] <= btb_wtag;
  end

  assign tag_rd      = byp ? btb_wtag : tag[idx];
  assign hit         = (byp || valid[idx]) && (tag_rd == lookup_pc[31 -: TAG_BITS]);
  assign unused_bits = ^lookup_pc[1:0];
`else
  logic unused_bits;

  assign hit         = byp || valid[idx];
  assign unused_bits = ^{btb_wtag, lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bp      <= 1'b0;
      bp_addr <= '0;
    end else begin
      state_q <= state_d;
      bp      <= bp_d;
      bp_addr <= addr_d;
    end
  end

  // Flush beats stall; stall freezes the response even while writes land.
  always_comb begin
    state_d = state_q;
    bp_d    = bp;
    addr_d  = bp_addr;
    if (flush) begin
      state_d = IDLE;
      bp_d    = 1'b0;
      addr_d  = '0;
    end else if (lookup_stall) begin
      state_d = state_q;
    end else if (lookup_req) begin
      state_d = HOLD;
      bp_d    = hit;
      addr_d  = hit ? tgt : 32'h0;
    end else begin
      state_d = IDLE;
      bp_d    = 1'b0;
      addr_d  = '0;
    end
  end

  assign resp_valid = (state_q == HOLD);

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed test-plan steps then random traffic against a table-level model.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst, lookup_req, lookup_stall, flush, btb_web;
  logic [31:0] lookup_pc, btb_din;
  logic [7:0]  btb_addr;
  logic [21:0] btb_wtag;
  logic        resp_valid, bp;
  logic [31:0] bp_addr;

  int total = 0;
  int bad   = 0;

  // Reference state: what the table holds and what the response should show.
  bit          m_v [256];
  logic [31:0] m_t [256];
  logic [21:0] m_g [256];
  logic        e_rv, e_bp;
  logic [31:0] e_addr;

  btb_predictor dut (
    .clk(clk), .rst(rst), .lookup_req(lookup_req), .lookup_pc(lookup_pc),
    .lookup_stall(lookup_stall), .flush(flush), .btb_web(btb_web),
    .btb_addr(btb_addr), .btb_din(btb_din), .btb_wtag(btb_wtag),
    .resp_valid(resp_valid), .bp(bp), .bp_addr(bp_addr)
  );

  always #5 clk = ~clk;

  function automatic bit model_hit(input logic [31:0] pc, output logic [31:0] t);
    int i;
    bit v;
    logic [21:0] g;
    i = int'(pc[9:2]);
    v = m_v[i];
    t = m_t[i];
    g = m_g[i];
    if (btb_web == 1'b0 && int'(btb_addr) == i) begin
      v = 1'b1;
      t = btb_din;
      g = btb_wtag;
    end
`ifdef BTB_TAG_CHECK_EN
    return v && (g == pc[31:10]);
`else
    return v;
`endif
  endfunction

  task automatic model_edge();
    logic [31:0] t;
    bit h;
    if (rst) begin
      e_rv = 0; e_bp = 0; e_addr = 0;
      for (int i = 0; i < 256; i++) m_v[i] = 0;
      return;
    end
    if (flush) begin
      e_rv = 0; e_bp = 0; e_addr = 0;
    end else if (lookup_stall) begin
      // response frozen
    end else if (lookup_req) begin
      h = model_hit(lookup_pc, t);
      e_rv = 1; e_bp = h; e_addr = h ? t : 32'h0;
    end else begin
      e_rv = 0; e_bp = 0; e_addr = 0;
    end
    if (!btb_web) begin
      m_v[btb_addr] = 1;
      m_t[btb_addr] = btb_din;
      m_g[btb_addr] = btb_wtag;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string tag);
    total++;
    assert (resp_valid === e_rv) else begin
      bad++; $error("FAIL %s resp_valid got %0h want %0h", tag, resp_valid, e_rv);
    end
    total++;
    assert (bp === e_bp) else begin
      bad++; $error("FAIL %s bp got %0h want %0h", tag, bp, e_bp);
    end
    total++;
    assert (bp_addr === e_addr) else begin
      bad++; $error("FAIL %s bp_addr got %0h want %0h", tag, bp_addr, e_addr);
    end
  endtask

  task automatic chk_const(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++; $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic idle_in();
    rst = 0; lookup_req = 0; lookup_stall = 0; flush = 0; btb_web = 1;
    lookup_pc = 0; btb_addr = 0; btb_din = 0; btb_wtag = 0;
  endtask

  initial begin
    idle_in();
    e_rv = 0; e_bp = 0; e_addr = 0;
    for (int i = 0; i < 256; i++) begin m_v[i] = 0; m_t[i] = 0; m_g[i] = 0; end
    #2;

    // reset
    rst = 1; step(); step(); rst = 0;
    chk("reset");
    chk_const("reset_rv", {31'b0, resp_valid}, 32'h0);

    // cold miss
    lookup_req = 1; lookup_pc = 32'h6000_0014; step(); lookup_req = 0;
    chk("cold_miss");
    chk_const("cold_miss_rv", {31'b0, resp_valid}, 32'h1);
    chk_const("cold_miss_bp", {31'b0, bp}, 32'h0);

    // write then lookup next cycle
    btb_web = 0; btb_addr = 8'h05; btb_din = 32'h6000_0100; btb_wtag = 22'h180000;
    step(); btb_web = 1;
    lookup_req = 1; lookup_pc = 32'h6000_0014; step(); lookup_req = 0;
    chk("hit_after_write");
    chk_const("hit_after_write_addr", bp_addr, 32'h6000_0100);

    // same-cycle write + lookup bypass
    btb_web = 0; btb_addr = 8'h05; btb_din = 32'h6000_0200; btb_wtag = 22'h180000;
    lookup_req = 1; lookup_pc = 32'h6000_0014; step(); btb_web = 1; lookup_req = 0;
    chk("bypass");
    chk_const("bypass_addr", bp_addr, 32'h6000_0200);

    // aliasing PC, same index different tag
    lookup_req = 1; lookup_pc = 32'h6000_0414; step(); lookup_req = 0;
    chk("alias");
`ifdef BTB_TAG_CHECK_EN
    chk_const("alias_bp", {31'b0, bp}, 32'h0);
`else
    chk_const("alias_addr", bp_addr, 32'h6000_0200);
`endif

    // stall holds a hit while a missing PC is presented and a write lands
    lookup_req = 1; lookup_pc = 32'h6000_0014; step();
    chk("pre_stall_hit");
    lookup_pc = 32'h6000_0018; lookup_stall = 1;
    for (int i = 0; i < 3; i++) begin
      btb_web = (i == 1) ? 1'b0 : 1'b1; btb_addr = 8'h05; btb_din = 32'h6000_0300;
      step();
      chk("stall_hold");
      chk_const("stall_hold_addr", bp_addr, 32'h6000_0200);
    end
    btb_web = 1; lookup_stall = 0; step(); lookup_req = 0;
    chk("after_stall_miss");
    chk_const("after_stall_bp", {31'b0, bp}, 32'h0);

    // flush with a hitting request, then reset wipes the table
    lookup_req = 1; flush = 1; lookup_pc = 32'h6000_0014; step(); flush = 0; lookup_req = 0;
    chk("flush");
    chk_const("flush_rv", {31'b0, resp_valid}, 32'h0);
    rst = 1; btb_web = 0; btb_addr = 8'h07; btb_din = 32'h1234_5678; step();
    rst = 0; btb_web = 1;
    chk("reset2");
    lookup_req = 1; lookup_pc = 32'h6000_0014; step();
    chk("miss_after_reset");
    chk_const("miss_after_reset_bp", {31'b0, bp}, 32'h0);
    lookup_pc = 32'h6000_001c; step(); lookup_req = 0;
    chk("reset_beats_write");

    // random traffic on a small index/tag pool to force hits, aliasing and bypass
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      lookup_stall = ($urandom_range(0, 3) == 0);
      lookup_req   = ($urandom_range(0, 1) == 1);
      btb_web      = ($urandom_range(0, 2) != 0);
      lookup_pc    = {22'h180000 + 22'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                      2'($urandom_range(0, 3))};
      btb_addr     = 8'($urandom_range(0, 7));
      btb_wtag     = 22'h180000 + 22'($urandom_range(0, 1));
      btb_din      = $urandom;
      step();
      chk("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
